rv64i_multicycle_control_unit: RTL and testbench
================================================

Name: rv64i_multicycle_control_unit

Overview:
Multicycle RV64I control unit that sequences Fetch, Decode, Execute and Memory-wait states. It drives every select and enable of the core datapath and the memory-controller request lines. It decodes opcode/funct3/funct7 and the ALU flags (zero, negative, carry_out, overflow) supplied by the datapath. It is paired with the Dataflow datapath and a shared memory controller: instruction fetch uses the PC address, data access uses the ALU address.

Parameters:
None.

Ports:
clock  in  1  system clock; all state changes on rising edge
reset  in  1  asynchronous, active-low reset
mem_busy  in  1  memory controller busy; rises after a request, falls when the access completes
opcode  in  7  instruction opcode from the instruction register
funct3  in  3  instruction funct3
funct7  in  7  instruction funct7
zero, negative, carry_out, overflow  in  1 each  ALU flags from the datapath
mem_rd_en  out  1  memory read request
mem_wr_en  out  1  memory write request
mem_byte_en  out  8  byte lanes of the access
mem_addr_src  out  1  memory address select: 0 = PC, 1 = ALU result
ir_en  out  1  instruction register load
alua_src  out  1  ALU A select: 0 = rs1, 1 = PC
alub_src  out  1  ALU B select: 0 = rs2, 1 = immediate
aluy_src  out  1  ALU result select: 0 = 64-bit result, 1 = low 32 bits sign-extended
alu_src  out  3  ALU operation code (funct3 encoding)
sub  out  1  ALU subtract
arithmetic  out  1  arithmetic (sign-filling) right shift
alupc_src  out  1  jump base: 0 = PC+imm, 1 = ALU result
pc_src  out  1  next PC: 0 = PC+4, 1 = jump/branch target
pc_en  out  1  PC load
wr_reg_src  out  2  register write-back select: 00 = ALU, 01 = memory data, 10 = PC+4, 11 = immediate
wr_reg_en  out  1  register file write

Behaviour:
General rules
- Moore outputs, with the Mealy exceptions noted below.
- Any output not listed for a state is 0.

States and transitions
- Reset (reset=0, asynchronous) enters IDLE, where all outputs are 0.
- IDLE goes to FETCH on the first rising edge with reset=1.
- FETCH:
  - Outputs: mem_rd_en=1, mem_byte_en=0x0F, mem_addr_src=0.
  - Moves to FETCH_WAIT on an edge where mem_busy=1.
- FETCH_WAIT:
  - Outputs: mem_rd_en=0, mem_byte_en=0x0F, ir_en = ~mem_busy (Mealy).
  - Moves to DECODE on an edge where mem_busy=0.
- DECODE: all enables are 0. Always moves to EXECUTE.
- EXECUTE, datapath selects by opcode:
  - OP 0110011 and OP-32 0111011:
    - alub_src=0, alu_src=funct3.
    - sub=1 when funct3=000 and funct7[5]=1, or when funct3 is 010 or 011.
    - arithmetic = funct7[5] when funct3=101.
  - OP-IMM 0010011 and OP-IMM-32 0011011:
    - alub_src=1, alu_src=funct3.
    - sub=1 for funct3 010 or 011.
    - arithmetic = funct7[5] when funct3=101.
  - For all four OP/OP-IMM opcodes: aluy_src = opcode[3], wr_reg_src=00, wr_reg_en=1, pc_en=1.
  - LUI 0110111: wr_reg_src=11, wr_reg_en=1, pc_en=1.
  - AUIPC 0010111: alua_src=1, alub_src=1, alu_src=000, wr_reg_src=00, wr_reg_en=1, pc_en=1.
  - JAL 1101111: alupc_src=0, pc_src=1, wr_reg_src=10, wr_reg_en=1, pc_en=1.
  - JALR 1100111: alub_src=1, alu_src=000, alupc_src=1, pc_src=1, wr_reg_src=10, wr_reg_en=1, pc_en=1.
  - BRANCH 1100011: alub_src=0, alu_src=000, sub=1, alupc_src=0, pc_en=1, wr_reg_en=0. pc_src by funct3:
    - funct3[2:1]=00: zero^funct3[0]
    - funct3[2:1]=10: negative^overflow^funct3[0]
    - funct3[2:1]=11: carry_out XNOR funct3[0]
    - funct3[2:1]=01: pc_src=0
  - LOAD 0000011:
    - alub_src=1, alu_src=000, mem_addr_src=1, mem_rd_en=1, wr_reg_src=01, wr_reg_en=0, pc_en=0.
  - STORE 0100011:
    - alub_src=1, alu_src=000, mem_addr_src=1, mem_wr_en=1, pc_en=0.
  - mem_byte_en for LOAD/STORE from funct3[1:0]: 00 = 0x01, 01 = 0x03, 10 = 0x0F, 11 = 0xFF.
  - Next state: single-cycle classes return to FETCH; LOAD/STORE go to MEM_WAIT on an edge with mem_busy=1; any other opcode (including 0000000) goes to HALT.
- MEM_WAIT:
  - Holds mem_addr_src, mem_byte_en, wr_reg_src and the ALU selects from EXECUTE; mem_rd_en=mem_wr_en=0.
  - pc_en = ~mem_busy; for LOAD, wr_reg_en = ~mem_busy (Mealy).
  - Moves to FETCH on an edge where mem_busy=0.
- HALT: all outputs 0 until reset.

Boundary rules
- Reset mid-access aborts immediately to IDLE.
- Request lines stay asserted until mem_busy is sampled high.

Test Plan:
- Reset: hold reset=0 -> all outputs 0; release -> outputs stay 0 for that cycle, then FETCH shows mem_rd_en=1, mem_byte_en=0x0F, ir_en=0.
- Fetch handshake: mem_busy high then low -> mem_rd_en=0 and ir_en=1 while busy=0; next cycle (DECODE) all enables 0.
- ADD/SUB/SRAI/ADDW: SUB (funct7=0100000, funct3=000) -> sub=1, wr_reg_en=1, pc_en=1; SRAI -> arithmetic=1, alub_src=1; ADDW -> aluy_src=1.
- Branches:
  - BEQ with zero=1 -> pc_src=1; BNE with zero=1 -> pc_src=0.
  - BLT with negative=1, overflow=0 -> pc_src=1.
  - BGEU with carry_out=1 -> pc_src=1.
- LD (funct3=011): EXECUTE mem_rd_en=1, mem_byte_en=0xFF, mem_addr_src=1, wr_reg_en=0 -> after busy falls, pc_en=1, wr_reg_en=1, mem_rd_en=0.
- SB: mem_wr_en=1, mem_byte_en=0x01 -> after busy falls, pc_en=1, wr_reg_en=0. Opcode 0000000 -> HALT with all outputs 0.

Source files
------------

// File: rtl/rv64i_multicycle_control_unit_if.sv
// Request/handshake bundle between the RV64I control unit and the shared memory controller.
interface rv64i_multicycle_control_unit_if;
  logic       mem_busy;
  logic       mem_rd_en;
  logic       mem_wr_en;
  logic [7:0] mem_byte_en;
  logic       mem_addr_src;

  modport master (input mem_busy, output mem_rd_en, mem_wr_en, mem_byte_en, mem_addr_src);
  modport slave  (output mem_busy, input mem_rd_en, mem_wr_en, mem_byte_en, mem_addr_src);
endinterface

// File: rtl/rv64i_multicycle_control_unit.sv
// Multicycle RV64I control unit: sequences fetch, decode, execute and memory-wait,
// driving every datapath select/enable and the memory-controller request lines.
module rv64i_multicycle_control_unit (
  input  logic                                   clock,
  input  logic                                   reset,
  rv64i_multicycle_control_unit_if.master        mem,
  input  logic [6:0]                             opcode,
  input  logic [2:0]                             funct3,
  input  logic [6:0]                             funct7,
  input  logic                                   zero,
  input  logic                                   negative,
  input  logic                                   carry_out,
  input  logic                                   overflow,
  output logic                                   ir_en,
  output logic                                   alua_src,
  output logic                                   alub_src,
  output logic                                   aluy_src,
  output logic [2:0]                             alu_src,
  output logic                                   sub,
  output logic                                   arithmetic,
  output logic                                   alupc_src,
  output logic                                   pc_src,
  output logic                                   pc_en,
  output logic [1:0]                             wr_reg_src,
  output logic                                   wr_reg_en
);
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  typedef enum logic [2:0] {IDLE, FETCH, FETCH_WAIT, DECODE, EXECUTE, MEM_WAIT, HALT} state_t;

  state_t     state, next_state;
  logic       is_load, is_store, is_alu_reg, is_alu_imm;
  logic [7:0] ls_byte_en;
  logic       branch_taken;
  logic       unused_funct7;

  assign is_load       = (opcode == OP_LOAD);
  assign is_store      = (opcode == OP_STORE);
  assign is_alu_reg    = (opcode == OP_REG) || (opcode == OP_REG32);
  assign is_alu_imm    = (opcode == OP_IMM) || (opcode == OP_IMM32);
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_comb begin
    ls_byte_en = 8'h01;
    case (funct3[1:0])
      2'b00:   ls_byte_en = 8'h01;
      2'b01:   ls_byte_en = 8'h03;
      2'b10:   ls_byte_en = 8'h0F;
      default: ls_byte_en = 8'hFF;
    endcase
  end

  // carry_out set means no borrow, i.e. unsigned a >= b
  always_comb begin
    branch_taken = 1'b0;
    case (funct3[2:1])
      2'b00:   branch_taken = zero ^ funct3[0];
      2'b10:   branch_taken = negative ^ overflow ^ funct3[0];
      2'b11:   branch_taken = ~(carry_out ^ funct3[0]);
      default: branch_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state       = state;
    mem.mem_rd_en    = 1'b0;
    mem.mem_wr_en    = 1'b0;
    mem.mem_byte_en  = 8'h00;
    mem.mem_addr_src = 1'b0;
    ir_en            = 1'b0;
    alua_src         = 1'b0;
    alub_src         = 1'b0;
    aluy_src         = 1'b0;
    alu_src          = 3'b000;
    sub              = 1'b0;
    arithmetic       = 1'b0;
    alupc_src        = 1'b0;
    pc_src           = 1'b0;
    pc_en            = 1'b0;
    wr_reg_src       = 2'b00;
    wr_reg_en        = 1'b0;
    case (state)
      IDLE: next_state = FETCH;
      FETCH: begin
        mem.mem_rd_en   = 1'b1;
        mem.mem_byte_en = 8'h0F;
        if (mem.mem_busy) next_state = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        mem.mem_byte_en = 8'h0F;
        ir_en           = ~mem.mem_busy;
        if (!mem.mem_busy) next_state = DECODE;
      end
      DECODE: next_state = EXECUTE;
      EXECUTE: begin
        next_state = HALT;
        if (is_alu_reg || is_alu_imm) begin
          alub_src   = is_alu_imm;
          alu_src    = funct3;
          sub        = (funct3 == 3'b010) || (funct3 == 3'b011) ||
                       (is_alu_reg && funct3 == 3'b000 && funct7[5]);
          arithmetic = (funct3 == 3'b101) && funct7[5];
          aluy_src   = opcode[3];
          wr_reg_en  = 1'b1;
          pc_en      = 1'b1;
          next_state = FETCH;
        end else begin
          case (opcode)
            OP_LUI: begin
              wr_reg_src = 2'b11;
              wr_reg_en  = 1'b1;
              pc_en      = 1'b1;
              next_state = FETCH;
            end
            OP_AUIPC: begin
              alua_src   = 1'b1;
              alub_src   = 1'b1;
              wr_reg_en  = 1'b1;
              pc_en      = 1'b1;
              next_state = FETCH;
            end
            OP_JAL: begin
              pc_src     = 1'b1;
              wr_reg_src = 2'b10;
              wr_reg_en  = 1'b1;
              pc_en      = 1'b1;
              next_state = FETCH;
            end
            OP_JALR: begin
              alub_src   = 1'b1;
              alupc_src  = 1'b1;
              pc_src     = 1'b1;
              wr_reg_src = 2'b10;
              wr_reg_en  = 1'b1;
              pc_en      = 1'b1;
              next_state = FETCH;
            end
            OP_BRANCH: begin
              sub        = 1'b1;
              pc_src     = branch_taken;
              pc_en      = 1'b1;
              next_state = FETCH;
            end
            OP_LOAD, OP_STORE: begin
              alub_src         = 1'b1;
              mem.mem_addr_src = 1'b1;
              mem.mem_byte_en  = ls_byte_en;
              mem.mem_rd_en    = is_load;
              mem.mem_wr_en    = is_store;
              wr_reg_src       = is_load ? 2'b01 : 2'b00;
              next_state       = mem.mem_busy ? MEM_WAIT : EXECUTE;
            end
            default: next_state = HALT;
          endcase
        end
      end
      // The instruction register is frozen here, so the load/store selects
      // recomputed from opcode/funct3 match what EXECUTE drove.
      MEM_WAIT: begin
        alub_src         = 1'b1;
        mem.mem_addr_src = 1'b1;
        mem.mem_byte_en  = ls_byte_en;
        wr_reg_src       = is_load ? 2'b01 : 2'b00;
        pc_en            = ~mem.mem_busy;
        wr_reg_en        = is_load & ~mem.mem_busy;
        if (!mem.mem_busy) next_state = FETCH;
      end
      HALT: next_state = HALT;
      default: next_state = IDLE;
    endcase
  end
endmodule

// File: tb/tb_rv64i_multicycle_control_unit.sv
// Directed, table-driven bench for the RV64I multicycle control unit, plus hand-written
// sequences for the fetch handshake, load/store waits, halt and reset mid-access.
module tb_rv64i_multicycle_control_unit;
  typedef struct packed {
    logic       mem_rd_en;
    logic       mem_wr_en;
    logic [7:0] mem_byte_en;
    logic       mem_addr_src;
    logic       ir_en;
    logic       alua_src;
    logic       alub_src;
    logic       aluy_src;
    logic [2:0] alu_src;
    logic       sub;
    logic       arithmetic;
    logic       alupc_src;
    logic       pc_src;
    logic       pc_en;
    logic [1:0] wr_reg_src;
    logic       wr_reg_en;
  } ctrl_t;

  typedef struct {
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [3:0] flags;
    ctrl_t      exp;
  } vec_t;

  localparam int NUM_VECS = 20;
  localparam ctrl_t ALL_ZERO  = '0;
  localparam ctrl_t FETCH_EXP = '{mem_rd_en: 1'b1, mem_byte_en: 8'h0F, default: '0};

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic       zero = 1'b0, negative = 1'b0, carry_out = 1'b0, overflow = 1'b0;
  logic       ir_en, alua_src, alub_src, aluy_src, sub, arithmetic, alupc_src, pc_src, pc_en, wr_reg_en;
  logic [2:0] alu_src;
  logic [1:0] wr_reg_src;
  ctrl_t      actual;
  int         compared = 0;
  int         mismatched = 0;
  vec_t       vecs [NUM_VECS];

  rv64i_multicycle_control_unit_if bus();

  rv64i_multicycle_control_unit dut (
    .clock(clock), .reset(reset), .mem(bus),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .zero(zero), .negative(negative), .carry_out(carry_out), .overflow(overflow),
    .ir_en(ir_en), .alua_src(alua_src), .alub_src(alub_src), .aluy_src(aluy_src),
    .alu_src(alu_src), .sub(sub), .arithmetic(arithmetic), .alupc_src(alupc_src),
    .pc_src(pc_src), .pc_en(pc_en), .wr_reg_src(wr_reg_src), .wr_reg_en(wr_reg_en)
  );

  always #5 clock = ~clock;

  assign actual = {bus.mem_rd_en, bus.mem_wr_en, bus.mem_byte_en, bus.mem_addr_src, ir_en,
                   alua_src, alub_src, aluy_src, alu_src, sub, arithmetic, alupc_src,
                   pc_src, pc_en, wr_reg_src, wr_reg_en};

  task automatic check_output(input string name, input ctrl_t expected);
    #1;
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [6:0] op, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [3:0] flags);
    opcode = op;
    funct3 = f3;
    funct7 = f7;
    {zero, negative, carry_out, overflow} = flags;
  endtask

  task automatic set_vec(input int idx, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [3:0] flags, input ctrl_t e);
    vecs[idx].opcode = op;
    vecs[idx].funct3 = f3;
    vecs[idx].funct7 = f7;
    vecs[idx].flags  = flags;
    vecs[idx].exp    = e;
  endtask

  // Starts at a negedge in FETCH and ends at the negedge in EXECUTE.
  task automatic go_to_execute(input logic [6:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [3:0] flags);
    apply_stimulus(op, f3, f7, flags);
    bus.mem_busy = 1'b1;
    @(negedge clock);
    bus.mem_busy = 1'b0;
    @(negedge clock);
    @(negedge clock);
  endtask

  initial begin
    ctrl_t ld_exec, ld_wait, sb_exec, sb_wait;
    bus.mem_busy = 1'b0;

    // flags order: {zero, negative, carry_out, overflow}
    set_vec(0,  7'b0110011, 3'b000, 7'b0000000, 4'b0000, '{wr_reg_en: 1'b1, pc_en: 1'b1, default: '0});
    set_vec(1,  7'b0110011, 3'b000, 7'b0100000, 4'b0000, '{sub: 1'b1, wr_reg_en: 1'b1, pc_en: 1'b1, default: '0});
    set_vec(2,  7'b0110011, 3'b011, 7'b0000000, 4'b0000, '{alu_src: 3'b011, sub: 1'b1, wr_reg_en: 1'b1, pc_en: 1'b1, default: '0});
    set_vec(3,  7'b0110011, 3'b101, 7'b0100000, 4'b0000, '{alu_src: 3'b101, arithmetic: 1'b1, wr_reg_en: 1'b1, pc_en: 1'b1, default: '0});
    set_vec(4,  7'b0010011, 3'b101, 7'b0100000, 4'b0000, '{alub_src: 1'b1, alu_src: 3'b101, arithmetic: 1'b1, wr_reg_en: 1'b1, pc_en: 1'b1, default: '0});
    set_vec(5,  7'b0010011, 3'b000, 7'b0100000, 4'b0000, '{alub_src: 1'b1, wr_reg_en: 1'b1, pc_en: 1'b1, default: '0});
    set_vec(6,  7'b0010011, 3'b010, 7'b0000000, 4'b0000, '{alub_src: 1'b1, alu_src: 3'b010, sub: 1'b1, wr_reg_en: 1'b1, pc_en: 1'b1, default: '0});
    set_vec(7,  7'b0111011, 3'b000, 7'b0000000, 4'b0000, '{aluy_src: 1'b1, wr_reg_en: 1'b1, pc_en: 1'b1, default: '0});
    set_vec(8,  7'b0011011, 3'b000, 7'b0000000, 4'b0000, '{alub_src: 1'b1, aluy_src: 1'b1, wr_reg_en: 1'b1, pc_en: 1'b1, default: '0});
    set_vec(9,  7'b0110111, 3'b000, 7'b0000000, 4'b0000, '{wr_reg_src: 2'b11, wr_reg_en: 1'b1, pc_en: 1'b1, default: '0});
    set_vec(10, 7'b0010111, 3'b000, 7'b0000000, 4'b0000, '{alua_src: 1'b1, alub_src: 1'b1, wr_reg_en: 1'b1, pc_en: 1'b1, default: '0});
    set_vec(11, 7'b1101111, 3'b000, 7'b0000000, 4'b0000, '{pc_src: 1'b1, wr_reg_src: 2'b10, wr_reg_en: 1'b1, pc_en: 1'b1, default: '0});
    set_vec(12, 7'b1100111, 3'b000, 7'b0000000, 4'b0000, '{alub_src: 1'b1, alupc_src: 1'b1, pc_src: 1'b1, wr_reg_src: 2'b10, wr_reg_en: 1'b1, pc_en: 1'b1, default: '0});
    set_vec(13, 7'b1100011, 3'b000, 7'b0000000, 4'b1000, '{sub: 1'b1, pc_src: 1'b1, pc_en: 1'b1, default: '0});
    set_vec(14, 7'b1100011, 3'b001, 7'b0000000, 4'b1000, '{sub: 1'b1, pc_en: 1'b1, default: '0});
    set_vec(15, 7'b1100011, 3'b100, 7'b0000000, 4'b0100, '{sub: 1'b1, pc_src: 1'b1, pc_en: 1'b1, default: '0});
    set_vec(16, 7'b1100011, 3'b101, 7'b0000000, 4'b0101, '{sub: 1'b1, pc_src: 1'b1, pc_en: 1'b1, default: '0});
    set_vec(17, 7'b1100011, 3'b111, 7'b0000000, 4'b0010, '{sub: 1'b1, pc_src: 1'b1, pc_en: 1'b1, default: '0});
    set_vec(18, 7'b1100011, 3'b110, 7'b0000000, 4'b0010, '{sub: 1'b1, pc_en: 1'b1, default: '0});
    set_vec(19, 7'b1100011, 3'b010, 7'b0000000, 4'b1000, '{sub: 1'b1, pc_en: 1'b1, default: '0});

    ld_exec = '{mem_rd_en: 1'b1, mem_byte_en: 8'hFF, mem_addr_src: 1'b1, alub_src: 1'b1, wr_reg_src: 2'b01, default: '0};
    ld_wait = '{mem_byte_en: 8'hFF, mem_addr_src: 1'b1, alub_src: 1'b1, wr_reg_src: 2'b01, default: '0};
    sb_exec = '{mem_wr_en: 1'b1, mem_byte_en: 8'h01, mem_addr_src: 1'b1, alub_src: 1'b1, default: '0};
    sb_wait = '{mem_byte_en: 8'h01, mem_addr_src: 1'b1, alub_src: 1'b1, default: '0};

    check_output("reset_held", ALL_ZERO);
    @(negedge clock);
    reset = 1'b1;
    check_output("idle_after_release", ALL_ZERO);
    @(negedge clock);
    check_output("fetch", FETCH_EXP);

    // Fetch handshake observed state by state.
    apply_stimulus(7'b0110011, 3'b000, 7'b0100000, 4'b0000);
    bus.mem_busy = 1'b1;
    check_output("fetch_busy", FETCH_EXP);
    @(negedge clock);
    check_output("fetch_wait_busy", '{mem_byte_en: 8'h0F, default: '0});
    bus.mem_busy = 1'b0;
    check_output("fetch_wait_done", '{mem_byte_en: 8'h0F, ir_en: 1'b1, default: '0});
    @(negedge clock);
    check_output("decode", ALL_ZERO);
    @(negedge clock);
    check_output("first_sub_exec", vecs[1].exp);
    @(negedge clock);
    check_output("first_sub_back_to_fetch", FETCH_EXP);

    for (int i = 0; i < NUM_VECS; i++) begin
      go_to_execute(vecs[i].opcode, vecs[i].funct3, vecs[i].funct7, vecs[i].flags);
      check_output($sformatf("vec%0d_exec", i), vecs[i].exp);
      @(negedge clock);
      check_output($sformatf("vec%0d_fetch", i), FETCH_EXP);
    end

    // LD: request held until busy is seen, write-back only once busy falls.
    go_to_execute(7'b0000011, 3'b011, 7'b0000000, 4'b0000);
    check_output("ld_exec", ld_exec);
    @(negedge clock);
    check_output("ld_exec_held", ld_exec);
    bus.mem_busy = 1'b1;
    @(negedge clock);
    check_output("ld_wait_busy", ld_wait);
    bus.mem_busy = 1'b0;
    check_output("ld_wait_done", '{mem_byte_en: 8'hFF, mem_addr_src: 1'b1, alub_src: 1'b1, wr_reg_src: 2'b01, pc_en: 1'b1, wr_reg_en: 1'b1, default: '0});
    @(negedge clock);
    check_output("ld_fetch", FETCH_EXP);

    // SB: no register write-back after the access completes.
    go_to_execute(7'b0100011, 3'b000, 7'b0000000, 4'b0000);
    check_output("sb_exec", sb_exec);
    bus.mem_busy = 1'b1;
    @(negedge clock);
    check_output("sb_wait_busy", sb_wait);
    bus.mem_busy = 1'b0;
    check_output("sb_wait_done", '{mem_byte_en: 8'h01, mem_addr_src: 1'b1, alub_src: 1'b1, pc_en: 1'b1, default: '0});
    @(negedge clock);
    check_output("sb_fetch", FETCH_EXP);

    go_to_execute(7'b0100011, 3'b010, 7'b0000000, 4'b0000);
    check_output("sw_exec", '{mem_wr_en: 1'b1, mem_byte_en: 8'h0F, mem_addr_src: 1'b1, alub_src: 1'b1, default: '0});
    bus.mem_busy = 1'b1;
    @(negedge clock);
    bus.mem_busy = 1'b0;
    @(negedge clock);
    check_output("sw_fetch", FETCH_EXP);

    // Illegal opcode halts until reset.
    go_to_execute(7'b0000000, 3'b000, 7'b0000000, 4'b1111);
    check_output("illegal_exec", ALL_ZERO);
    @(negedge clock);
    check_output("halt", ALL_ZERO);
    bus.mem_busy = 1'b1;
    @(negedge clock);
    check_output("halt_stays", ALL_ZERO);
    bus.mem_busy = 1'b0;

    reset = 1'b0;
    check_output("reset_from_halt", ALL_ZERO);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_output("fetch_after_halt_reset", FETCH_EXP);

    // Asynchronous reset in the middle of a load wait.
    go_to_execute(7'b0000011, 3'b001, 7'b0000000, 4'b0000);
    check_output("lh_exec", '{mem_rd_en: 1'b1, mem_byte_en: 8'h03, mem_addr_src: 1'b1, alub_src: 1'b1, wr_reg_src: 2'b01, default: '0});
    bus.mem_busy = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_output("reset_mid_access", ALL_ZERO);
    bus.mem_busy = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    check_output("idle_after_abort", ALL_ZERO);
    @(negedge clock);
    check_output("fetch_after_abort", FETCH_EXP);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
